// File: rtl/axil_lite_master_pkg.sv
// Shared AXI4-Lite definitions: response codes and the initiator FSM state encoding.
package axil_lite_master_pkg;

  localparam logic [1:0] RESP_OKAY   = 2'b00;
  localparam logic [1:0] RESP_EXOKAY = 2'b01;
  localparam logic [1:0] RESP_SLVERR = 2'b10;
  localparam logic [1:0] RESP_DECERR = 2'b11;

  typedef enum logic [2:0] {IDLE, WR, WR_B, RD, RD_R, RSP} axil_mst_state_t;

  function automatic logic is_unaligned(input logic [1:0] lsb);
    return lsb != 2'b00;
  endfunction

endpackage

// File: rtl/axil_lite_master_if.sv
// AXI4-Lite bus bundle (AW/W/B/AR/R); master drives valids/payload and bready/rready.
interface axil_lite_master_if #(
  parameter int ADDR_WIDTH = 32,
  parameter int DATA_WIDTH = 32
);
  logic [ADDR_WIDTH-1:0]   awaddr;
  logic                    awvalid;
  logic                    awready;
  logic [DATA_WIDTH-1:0]   wdata;
  logic [DATA_WIDTH/8-1:0] wstrb;
  logic                    wvalid;
  logic                    wready;
  logic [1:0]              bresp;
  logic                    bvalid;
  logic                    bready;
  logic [ADDR_WIDTH-1:0]   araddr;
  logic                    arvalid;
  logic                    arready;
  logic [DATA_WIDTH-1:0]   rdata;
  logic [1:0]              rresp;
  logic                    rvalid;
  logic                    rready;

  modport master (
    output awaddr, awvalid, wdata, wstrb, wvalid, bready, araddr, arvalid, rready,
    input  awready, wready, bresp, bvalid, arready, rdata, rresp, rvalid
  );

  modport slave (
    input  awaddr, awvalid, wdata, wstrb, wvalid, bready, araddr, arvalid, rready,
    output awready, wready, bresp, bvalid, arready, rdata, rresp, rvalid
  );
endinterface

// File: rtl/axil_lite_master_timeout_cnt.sv
// Saturating bus-phase cycle counter; expired stays high until clear. MAX=0 never expires.
module axil_timeout_cnt #(
  parameter int MAX = 1024
) (
  input  logic clk,
  input  logic rst_n,
  input  logic clear,
  input  logic enable,
  output logic expired
);
  localparam int W = (MAX < 2) ? 1 : $clog2(MAX + 1);
  localparam logic [W-1:0] LIMIT = W'(MAX);

  logic [W-1:0] cnt;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)                       cnt <= '0;
    else if (clear)                   cnt <= '0;
    else if (enable && cnt != LIMIT)  cnt <= cnt + 1'b1;
  end

  assign expired = (MAX != 0) && (cnt == LIMIT);
endmodule

// File: rtl/axil_lite_master.sv
// Single-outstanding AXI4-Lite initiator: command -> one AW/W or AR burst -> response port.
// Min latency 4 cycles accept->rsp_valid; cmd_ready only in IDLE, response held until rsp_ready.
module axil_lite_master
  import axil_lite_master_pkg::*;
#(
  parameter int ADDR_WIDTH     = 32,
  parameter int DATA_WIDTH     = 32,
  parameter int TIMEOUT_CYCLES = 1024
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  cmd_valid,
  output logic                  cmd_ready,
  input  logic                  cmd_rnw,
  input  logic [ADDR_WIDTH-1:0] cmd_addr,
  input  logic [DATA_WIDTH-1:0] cmd_wdata,
  input  logic [3:0]            cmd_wstrb,
  output logic                  rsp_valid,
  input  logic                  rsp_ready,
  output logic [DATA_WIDTH-1:0] rsp_rdata,
  output logic [1:0]            rsp_resp,
  output logic                  rsp_timeout,
  output logic                  busy,
  axil_lite_master_if.master    m_axil
);
  axil_mst_state_t state, state_nxt;

  logic [ADDR_WIDTH-1:0] addr_q;
  logic [DATA_WIDTH-1:0] wdata_q;
  logic [3:0]            wstrb_q;
  logic [DATA_WIDTH-1:0] rdata_q;
  logic [1:0]            resp_q;
  logic aw_vld, w_vld, ar_vld;
  logic aw_done, w_done, ar_done;
  logic accept, unaligned, aw_hs, w_hs, ar_hs, b_hs, r_hs, rsp_hs, bus_phase;

  assign accept    = cmd_valid && cmd_ready;
  assign unaligned = is_unaligned(cmd_addr[1:0]);
  assign aw_hs     = aw_vld && m_axil.awready;
  assign w_hs      = w_vld && m_axil.wready;
  assign ar_hs     = ar_vld && m_axil.arready;
  assign b_hs      = m_axil.bvalid && m_axil.bready;
  assign r_hs      = m_axil.rvalid && m_axil.rready;
  assign rsp_hs    = rsp_valid && rsp_ready;
  assign bus_phase = (state == WR) || (state == WR_B) || (state == RD) || (state == RD_R);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE: if (accept) state_nxt = unaligned ? RSP : (cmd_rnw ? RD : WR);
      WR:   if (aw_done && w_done) state_nxt = WR_B;
      WR_B: if (b_hs) state_nxt = RSP;
      RD:   if (ar_done) state_nxt = RD_R;
      RD_R: if (r_hs) state_nxt = RSP;
      RSP:  if (rsp_ready) state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_comb begin
    cmd_ready     = (state == IDLE);
    busy          = (state != IDLE);
    rsp_valid     = (state == RSP);
    m_axil.bready = (state == WR_B);
    m_axil.rready = (state == RD_R);
  end

  // Each channel's valid clears on its own handshake; done flags let AW and W finish in any order.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      addr_q  <= '0;
      wdata_q <= '0;
      wstrb_q <= '0;
      rdata_q <= '0;
      resp_q  <= RESP_OKAY;
      aw_vld  <= 1'b0;
      w_vld   <= 1'b0;
      ar_vld  <= 1'b0;
      aw_done <= 1'b0;
      w_done  <= 1'b0;
      ar_done <= 1'b0;
    end else begin
      if (accept) begin
        addr_q  <= cmd_addr;
        wdata_q <= cmd_wdata;
        wstrb_q <= cmd_wstrb;
        aw_done <= 1'b0;
        w_done  <= 1'b0;
        ar_done <= 1'b0;
        if (unaligned) begin
          rdata_q <= '0;
          resp_q  <= RESP_SLVERR;
        end else begin
          aw_vld <= !cmd_rnw;
          w_vld  <= !cmd_rnw;
          ar_vld <= cmd_rnw;
        end
      end
      if (aw_hs) begin
        aw_vld  <= 1'b0;
        aw_done <= 1'b1;
      end
      if (w_hs) begin
        w_vld  <= 1'b0;
        w_done <= 1'b1;
      end
      if (ar_hs) begin
        ar_vld  <= 1'b0;
        ar_done <= 1'b1;
      end
      if (b_hs) begin
        rdata_q <= '0;
        resp_q  <= m_axil.bresp;
      end
      if (r_hs) begin
        rdata_q <= m_axil.rdata;
        resp_q  <= m_axil.rresp;
      end
    end
  end

  assign m_axil.awaddr  = addr_q;
  assign m_axil.araddr  = addr_q;
  assign m_axil.wdata   = wdata_q;
  assign m_axil.wstrb   = wstrb_q;
  assign m_axil.awvalid = aw_vld;
  assign m_axil.wvalid  = w_vld;
  assign m_axil.arvalid = ar_vld;
  assign rsp_rdata      = rdata_q;
  assign rsp_resp       = resp_q;

  // The counter holds while in RSP so the timeout flag stays visible until the response is taken.
  axil_timeout_cnt #(.MAX(TIMEOUT_CYCLES)) u_timeout (
    .clk     (clk),
    .rst_n   (rst_n),
    .clear   (accept || rsp_hs),
    .enable  (bus_phase),
    .expired (rsp_timeout)
  );
endmodule

// File: tb/tb_axil_lite_master.sv
// Directed bench for axil_lite_master with a behavioural AXI-Lite slave (programmable delays).
module tb_axil_lite_master;
  import axil_lite_master_pkg::*;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        cmd_valid = 1'b0, cmd_ready, cmd_rnw = 1'b0;
  logic [31:0] cmd_addr = '0, cmd_wdata = '0;
  logic [3:0]  cmd_wstrb = '0;
  logic        rsp_valid, rsp_ready = 1'b1;
  logic [31:0] rsp_rdata;
  logic [1:0]  rsp_resp;
  logic        rsp_timeout, busy;

  always #5 clk = ~clk;

  axil_lite_master_if #(.ADDR_WIDTH(32), .DATA_WIDTH(32)) bus ();

  axil_lite_master #(.ADDR_WIDTH(32), .DATA_WIDTH(32), .TIMEOUT_CYCLES(1024)) dut (
    .clk(clk), .rst_n(rst_n),
    .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_rnw(cmd_rnw),
    .cmd_addr(cmd_addr), .cmd_wdata(cmd_wdata), .cmd_wstrb(cmd_wstrb),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_rdata(rsp_rdata),
    .rsp_resp(rsp_resp), .rsp_timeout(rsp_timeout), .busy(busy),
    .m_axil(bus)
  );

  int checks = 0, failures = 0;
  int cyc = 0, acc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int aw_dly = 0, w_dly = 0, ar_dly = 0, b_dly = 0, r_dly = 0;
  logic [1:0] b_resp_cfg = RESP_OKAY, r_resp_cfg = RESP_OKAY;
  int aw_hi, w_hi, ar_hi, n_b, n_r, aw_first, w_first, aw_last, w_last;
  bit aw_got, w_got, ar_got, b_fire, r_fire;
  int aw_wait, w_wait, ar_wait, b_wait, r_wait;
  logic [31:0] aw_a, w_d, ar_a;
  logic [3:0]  w_s;
  logic [31:0] mem [16];
  logic [31:0] got_rdata;
  logic [1:0]  got_resp;
  logic        got_to;
  int          lat;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s: observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  function automatic int rel(input int c);
    return c - acc + 1;
  endfunction

  // Slave model: acts on the falling edge, so the DUT samples its outputs on the next rising edge.
  initial begin
    for (int i = 0; i < 16; i++) mem[i] = '0;
    forever begin
      @(negedge clk);
      if (!rst_n) begin
        bus.awready = 0; bus.wready = 0; bus.arready = 0;
        bus.bvalid = 0; bus.bresp = 0; bus.rvalid = 0; bus.rresp = 0; bus.rdata = 0;
        aw_got = 0; w_got = 0; ar_got = 0; b_fire = 0; r_fire = 0;
        aw_wait = 0; w_wait = 0; ar_wait = 0; b_wait = 0; r_wait = 0;
      end else begin
        if (b_fire) begin bus.bvalid = 0; b_fire = 0; end
        if (r_fire) begin bus.rvalid = 0; r_fire = 0; end
        if (aw_got && w_got && !bus.bvalid) begin
          if (b_wait >= b_dly) begin
            for (int i = 0; i < 4; i++)
              if (w_s[i]) mem[aw_a[5:2]][8*i +: 8] = w_d[8*i +: 8];
            bus.bvalid = 1; bus.bresp = b_resp_cfg;
            aw_got = 0; w_got = 0; b_wait = 0;
          end else b_wait++;
        end
        if (ar_got && !bus.rvalid) begin
          if (r_wait >= r_dly) begin
            bus.rvalid = 1; bus.rdata = mem[ar_a[5:2]]; bus.rresp = r_resp_cfg;
            ar_got = 0; r_wait = 0;
          end else r_wait++;
        end
        bus.awready = 0; bus.wready = 0; bus.arready = 0;
        if (bus.awvalid) begin
          aw_hi++; aw_last = cyc; if (aw_first < 0) aw_first = cyc;
          if (!aw_got) begin
            if (aw_wait >= aw_dly) begin bus.awready = 1; aw_got = 1; aw_a = bus.awaddr; aw_wait = 0; end
            else aw_wait++;
          end
        end
        if (bus.wvalid) begin
          w_hi++; w_last = cyc; if (w_first < 0) w_first = cyc;
          if (!w_got) begin
            if (w_wait >= w_dly) begin bus.wready = 1; w_got = 1; w_d = bus.wdata; w_s = bus.wstrb; w_wait = 0; end
            else w_wait++;
          end
        end
        if (bus.arvalid) begin
          ar_hi++;
          if (!ar_got) begin
            if (ar_wait >= ar_dly) begin bus.arready = 1; ar_got = 1; ar_a = bus.araddr; ar_wait = 0; end
            else ar_wait++;
          end
        end
        if (bus.bvalid && bus.bready) begin b_fire = 1; n_b++; end
        if (bus.rvalid && bus.rready) begin r_fire = 1; n_r++; end
      end
    end
  end

  task automatic issue(input logic rnw, input logic [31:0] a, input logic [31:0] d, input logic [3:0] s);
    int n;
    n = 0;
    @(negedge clk);
    cmd_rnw = rnw; cmd_addr = a; cmd_wdata = d; cmd_wstrb = s; cmd_valid = 1;
    while (!cmd_ready && n < 50) begin @(negedge clk); n++; end
    check("cmd_ready_at_issue", cmd_ready, 1);
    @(posedge clk); #1;
    acc = cyc; cmd_valid = 0;
    aw_hi = 0; w_hi = 0; ar_hi = 0; n_b = 0; n_r = 0;
    aw_first = -1; w_first = -1; aw_last = -1; w_last = -1;
  endtask

  // lat = cycles after the accept edge until rsp_valid is seen; -1 if the bound expires.
  task automatic wait_rsp(input int limit);
    lat = -1;
    for (int k = 1; k <= limit; k++) begin
      @(negedge clk);
      if (rsp_valid) begin
        lat = k; got_rdata = rsp_rdata; got_resp = rsp_resp; got_to = rsp_timeout;
        break;
      end
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation exceeded time budget");
    $fatal(1, "watchdog");
  end

  initial begin
    #1;
    check("rst_cmd_ready", cmd_ready, 1);
    check("rst_busy_rsp_valid", {busy, rsp_valid, rsp_timeout}, 3'b000);
    check("rst_bus_valids", {bus.awvalid, bus.wvalid, bus.arvalid, bus.bready, bus.rready}, 5'b0);
    check("rst_rsp_payload", {rsp_rdata, rsp_resp}, 34'h0);
    repeat (3) @(negedge clk);
    rst_n = 1;

    // Write with always-ready slave: AW and W both in cycle 1, response in cycle 4.
    issue(0, 32'h08, 32'h1000_0040, 4'hF);
    wait_rsp(20);
    check("wr_latency", lat, 4);
    check("wr_resp", {got_resp, got_rdata, got_to}, {RESP_OKAY, 32'h0, 1'b0});
    check("wr_aw_w_timing", {rel(aw_first), rel(w_first), rel(aw_last), rel(w_last)},
          {32'd1, 32'd1, 32'd1, 32'd1});
    @(negedge clk);
    check("wr_one_b", n_b, 1);

    issue(1, 32'h08, 32'h0, 4'h0);
    wait_rsp(20);
    check("rd_latency", lat, 4);
    check("rd_data_resp", {got_rdata, got_resp}, {32'h1000_0040, RESP_OKAY});

    // arready asserted on the fifth cycle of arvalid.
    ar_dly = 4;
    issue(1, 32'h08, 32'h0, 4'h0);
    wait_rsp(30);
    ar_dly = 0;
    check("rd_ar_held", ar_hi, 5);
    check("rd_delayed_latency", lat, 8);
    check("rd_delayed_data", got_rdata, 32'h1000_0040);

    // W accepted in cycle 1, AW in cycle 6.
    aw_dly = 5;
    issue(0, 32'h0C, 32'hAABB_CCDD, 4'hF);
    wait_rsp(30);
    aw_dly = 0;
    check("wfirst_drop_cycles", {rel(w_last) + 1, rel(aw_last) + 1}, {32'd2, 32'd7});
    check("wfirst_latency", lat, 9);
    repeat (3) @(negedge clk);
    check("wfirst_one_b", n_b, 1);

    issue(0, 32'h0C, 32'h1122_3344, 4'b0011);
    wait_rsp(20);
    issue(1, 32'h0C, 32'h0, 4'h0);
    wait_rsp(20);
    check("strobe_merge", got_rdata, 32'hAABB_3344);

    issue(0, 32'h06, 32'h5555_5555, 4'hF);
    wait_rsp(10);
    check("unal_latency", lat, 1);
    check("unal_resp", {got_resp, got_rdata, got_to}, {RESP_SLVERR, 32'h0, 1'b0});
    repeat (3) @(negedge clk);
    check("unal_no_bus", aw_hi + w_hi + ar_hi, 0);

    r_resp_cfg = RESP_DECERR;
    issue(1, 32'h08, 32'h0, 4'h0);
    wait_rsp(20);
    r_resp_cfg = RESP_OKAY;
    check("rd_decerr", got_resp, RESP_DECERR);

    // Late B: the counter reaches 1024 in cycle 1025, B completes with RSP in cycle 1103.
    b_dly = 1100; b_resp_cfg = RESP_EXOKAY;
    issue(0, 32'h10, 32'h0000_0077, 4'hF);
    repeat (1024) @(negedge clk);
    check("to_before_limit", {rsp_timeout, busy}, 2'b01);
    @(negedge clk);
    check("to_at_limit", {rsp_timeout, busy, rsp_valid}, 3'b110);
    wait_rsp(200);
    b_dly = 0; b_resp_cfg = RESP_OKAY;
    check("to_latency", lat, 1103 - 1025);
    check("to_resp_kept", {got_resp, got_to}, {RESP_EXOKAY, 1'b1});
    @(negedge clk);
    check("to_cleared", rsp_timeout, 0);

    rsp_ready = 0;
    issue(1, 32'h08, 32'h0, 4'h0);
    wait_rsp(20);
    begin
      bit stable, rdy_seen;
      stable = 1; rdy_seen = 0;
      repeat (10) begin
        @(negedge clk);
        if (!(rsp_valid && rsp_rdata == 32'h1000_0040 && rsp_resp == RESP_OKAY)) stable = 0;
        if (cmd_ready) rdy_seen = 1;
      end
      check("hold_payload_stable", stable, 1);
      check("hold_cmd_ready_low", rdy_seen, 0);
    end
    rsp_ready = 1;
    @(negedge clk);
    check("hold_release", {rsp_valid, cmd_ready}, 2'b01);

    // Reset in the middle of a stalled write: valids drop without a clock edge.
    aw_dly = 20; w_dly = 20;
    issue(0, 32'h08, 32'hDEAD_BEEF, 4'hF);
    repeat (3) @(negedge clk);
    check("midwr_valids_up", {bus.awvalid, bus.wvalid, busy}, 3'b111);
    #2 rst_n = 0;
    #1;
    check("midwr_async_reset", {bus.awvalid, bus.wvalid, bus.arvalid, busy, cmd_ready}, 5'b00001);
    repeat (2) @(negedge clk);
    aw_dly = 0; w_dly = 0;
    rst_n = 1;
    issue(1, 32'h08, 32'h0, 4'h0);
    wait_rsp(20);
    check("after_reset_read", {lat, got_rdata}, {32'd4, 32'h1000_0040});

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
